// File: rtl/vga_sprite_mixer_pkg.sv
// Shared constants and types for the sprite mixer: RGB332 colours, default
// coordinate width and the per-channel blink state encoding.
package vga_sprite_mixer_pkg;

  localparam int DEF_COORD_W = 10;

  localparam logic [7:0] BLACK  = 8'h00;
  localparam logic [7:0] WHITE  = 8'hFF;
  localparam logic [7:0] RED    = 8'hE0;
  localparam logic [7:0] GREEN  = 8'h1C;
  localparam logic [7:0] BLUE   = 8'h03;
  localparam logic [7:0] YELLOW = 8'hFC;

  typedef enum logic [1:0] {
    BLK_IDLE = 2'd0,
    BLK_VIS  = 2'd1,
    BLK_HID  = 2'd2
  } blink_state_e;

endpackage

// File: rtl/sprite_rect_hit.sv
// Registered single-channel rectangle comparator (stage S1 of the mixer).
// Right/bottom edges are formed one bit wider so sprites at the screen edge do not wrap.
module sprite_rect_hit
  import vga_sprite_mixer_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [COORD_W-1:0] px_x_i,
  input  logic [COORD_W-1:0] px_y_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  output logic               hit_o
);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;
  logic             hit_d;
  logic             hit_q;

  assign x_end = {1'b0, x_i} + {1'b0, w_i};
  assign y_end = {1'b0, y_i} + {1'b0, h_i};

  assign hit_d = en_i
               & (px_x_i >= x_i) & ({1'b0, px_x_i} < x_end)
               & (px_y_i >= y_i) & ({1'b0, px_y_i} < y_end);

  // S1 boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/vga_sprite_mixer.sv
// N-channel rectangle sprite compositor with per-frame collision reporting.
// Optional blink support is compiled in with `define SPRITE_BLINK_EN.
module vga_sprite_mixer
  import vga_sprite_mixer_pkg::*;
#(
  parameter int         NUM_SPR     = 8,
  parameter int         COORD_W     = DEF_COORD_W,
  parameter logic [7:0] BG_COLOR    = BLACK,
  parameter int         BLINK_COUNT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       de_in,
  input  logic                       frame_in,
  input  logic [COORD_W-1:0]         px_x,
  input  logic [COORD_W-1:0]         px_y,
  input  logic [NUM_SPR-1:0]         spr_en,
  input  logic [NUM_SPR*COORD_W-1:0] spr_x,
  input  logic [NUM_SPR*COORD_W-1:0] spr_y,
  input  logic [NUM_SPR*COORD_W-1:0] spr_w,
  input  logic [NUM_SPR*COORD_W-1:0] spr_h,
  input  logic [NUM_SPR*8-1:0]       spr_color,
  input  logic                       clk_blink,
  input  logic [NUM_SPR-1:0]         blink_req,
  output logic [7:0]                 vga_out,
  output logic                       de_out,
  output logic [NUM_SPR-1:0]         coll_vec,
  output logic                       coll_valid,
  input  logic                       coll_ack,
  output logic                       coll_overrun,
  output logic [NUM_SPR-1:0]         blinking
);

  logic [NUM_SPR-1:0] hit_p1;
  logic               de_p1;
  logic               frame_p1;
  logic [NUM_SPR-1:0] vis;

  logic [7:0]         color_d;
  logic [7:0]         vga_out_p2;
  logic               de_out_p2;

  logic [NUM_SPR-1:0] contrib;
  logic [NUM_SPR-1:0] acc_new;
  logic [NUM_SPR-1:0] acc_q,      acc_d;
  logic [NUM_SPR-1:0] coll_vec_q, coll_vec_d;
  logic               valid_q,    valid_d;
  logic               overrun_q,  overrun_d;

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
    sprite_rect_hit #(
      .COORD_W(COORD_W)
    ) u_hit (
      .clk    (clk),
      .rst    (rst),
      .en_i   (spr_en[g]),
      .px_x_i (px_x),
      .px_y_i (px_y),
      .x_i    (spr_x[g*COORD_W +: COORD_W]),
      .y_i    (spr_y[g*COORD_W +: COORD_W]),
      .w_i    (spr_w[g*COORD_W +: COORD_W]),
      .h_i    (spr_h[g*COORD_W +: COORD_W]),
      .hit_o  (hit_p1[g])
    );
  end

  // S1 boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_p1    <= 1'b0;
      frame_p1 <= 1'b0;
    end else begin
      de_p1    <= de_in;
      frame_p1 <= frame_in;
    end
  end

  // Walk from lowest priority upwards so the lowest visible index wins.
  always_comb begin
    color_d = BG_COLOR;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_p1[i] && vis[i]) color_d = spr_color[i*8 +: 8];
    end
    if (!de_p1) color_d = BG_COLOR;
  end

  always_comb begin
    contrib = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      contrib[i] = hit_p1[i] & (|(hit_p1 & ~(NUM_SPR'(1) << i)));
    end
    if (!de_p1) contrib = '0;
    acc_new = acc_q | contrib;
  end

  // The current pixel's overlap is folded into the report so a frame pulse
  // that coincides with visible data never loses it.
  always_comb begin
    acc_d      = acc_new;
    coll_vec_d = coll_vec_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    if (frame_p1) begin
      acc_d = '0;
      if (!valid_q || coll_ack) begin
        coll_vec_d = acc_new;
        valid_d    = 1'b1;
        overrun_d  = 1'b0;
      end else begin
        coll_vec_d = coll_vec_q | acc_new;
        overrun_d  = 1'b1;
      end
    end else if (valid_q && coll_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // S2 boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_out_p2 <= BG_COLOR;
      de_out_p2  <= 1'b0;
      acc_q      <= '0;
      coll_vec_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      vga_out_p2 <= color_d;
      de_out_p2  <= de_p1;
      acc_q      <= acc_d;
      coll_vec_q <= coll_vec_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign vga_out      = vga_out_p2;
  assign de_out       = de_out_p2;
  assign coll_vec     = coll_vec_q;
  assign coll_valid   = valid_q;
  assign coll_overrun = overrun_q;

`ifdef SPRITE_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_COUNT + 1);

  blink_state_e       blk_q [NUM_SPR];
  blink_state_e       blk_d [NUM_SPR];
  logic [CNT_W-1:0]   cnt_q [NUM_SPR];
  logic [CNT_W-1:0]   cnt_d [NUM_SPR];
  logic [NUM_SPR-1:0] blinking_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        blk_q[i] <= BLK_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        blk_q[i] <= blk_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // A request restarts the sequence even when it lands on a phase strobe.
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      blk_d[i] = blk_q[i];
      cnt_d[i] = cnt_q[i];
      if (blink_req[i]) begin
        blk_d[i] = BLK_VIS;
        cnt_d[i] = '0;
      end else if (clk_blink) begin
        case (blk_q[i])
          BLK_VIS: blk_d[i] = BLK_HID;
          BLK_HID: begin
            if (cnt_q[i] + 1'b1 == CNT_W'(BLINK_COUNT)) begin
              blk_d[i] = BLK_IDLE;
              cnt_d[i] = '0;
            end else begin
              blk_d[i] = BLK_VIS;
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          default: blk_d[i] = blk_q[i];
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      blinking_q[i] = (blk_q[i] != BLK_IDLE);
      vis[i]        = (blk_q[i] != BLK_HID);
    end
  end

  assign blinking = blinking_q;
`else
  logic unused_blink;

  assign unused_blink = ^{clk_blink, blink_req, BLINK_COUNT != 0};
  assign vis          = '1;
  assign blinking     = '0;
`endif

endmodule

// File: tb/tb_vga_sprite_mixer.sv
// Directed bench for vga_sprite_mixer: pixel colours go through a scoreboard queue,
// collision report handshake and reset behaviour are checked directly.
module tb_vga_sprite_mixer;
  import vga_sprite_mixer_pkg::*;

  localparam int NS = 8;
  localparam int CW = 10;
  localparam logic [7:0] BG = 8'h00;

  logic             clk = 1'b0;
  logic             rst;
  logic             de_in, frame_in;
  logic [CW-1:0]    px_x, px_y;
  logic [NS-1:0]    spr_en;
  logic [NS*CW-1:0] spr_x, spr_y, spr_w, spr_h;
  logic [NS*8-1:0]  spr_color;
  logic             clk_blink;
  logic [NS-1:0]    blink_req;
  logic [7:0]       vga_out;
  logic             de_out;
  logic [NS-1:0]    coll_vec;
  logic             coll_valid;
  logic             coll_ack;
  logic             coll_overrun;
  logic [NS-1:0]    blinking;

  vga_sprite_mixer #(
    .NUM_SPR(NS), .COORD_W(CW), .BG_COLOR(BG), .BLINK_COUNT(3)
  ) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .frame_in(frame_in),
    .px_x(px_x), .px_y(px_y), .spr_en(spr_en),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
    .spr_color(spr_color), .clk_blink(clk_blink), .blink_req(blink_req),
    .vga_out(vga_out), .de_out(de_out), .coll_vec(coll_vec),
    .coll_valid(coll_valid), .coll_ack(coll_ack),
    .coll_overrun(coll_overrun), .blinking(blinking)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] col;
    logic       de;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         sx[NS], sy[NS], sw[NS], sh[NS];
  logic [7:0] scol[NS];
  bit [NS-1:0] sen = '0;
  bit [NS-1:0] hid = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_col(input int x, input int y, input bit de);
    if (!de) return BG;
    for (int i = 0; i < NS; i++) begin
      if (sen[i] && !hid[i] && x >= sx[i] && x < sx[i] + sw[i] &&
          y >= sy[i] && y < sy[i] + sh[i]) return scol[i];
    end
    return BG;
  endfunction

  // One pixel per call: compare the output due now, then drive and predict the next.
  task automatic tick(input int x, input int y, input bit de, input bit fr = 1'b0,
                      input bit ack = 1'b0, input bit breq = 1'b0, input bit cb = 1'b0);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      chk("pix_color", {24'd0, vga_out}, {24'd0, e.col});
      chk("pix_de", {31'd0, de_out}, {31'd0, e.de});
    end
    px_x      = x[CW-1:0];
    px_y      = y[CW-1:0];
    de_in     = de;
    frame_in  = fr;
    coll_ack  = ack;
    blink_req = breq ? NS'(1) : '0;
    clk_blink = cb;
    e.col = model_col(x, y, de);
    e.de  = de;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 1'b0);
  endtask

  task automatic sweep(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) tick(x, y, 1'b1);
  endtask

  task automatic frame_end();
    tick(0, 480, 1'b0, 1'b1);
  endtask

  task automatic set_spr(input int ch, input int x, input int y, input int w, input int h,
                         input logic [7:0] col, input bit en);
    idle(2);
    sx[ch] = x; sy[ch] = y; sw[ch] = w; sh[ch] = h; scol[ch] = col; sen[ch] = en;
    spr_x[ch*CW +: CW]  = x[CW-1:0];
    spr_y[ch*CW +: CW]  = y[CW-1:0];
    spr_w[ch*CW +: CW]  = w[CW-1:0];
    spr_h[ch*CW +: CW]  = h[CW-1:0];
    spr_color[ch*8 +: 8] = col;
    spr_en[ch]           = en;
  endtask

  task automatic chk_coll(input string tag, input logic [NS-1:0] vec, input bit v, input bit ovr);
    chk({tag, "_vec"}, {24'd0, coll_vec}, {24'd0, vec});
    chk({tag, "_valid"}, {31'd0, coll_valid}, {31'd0, v});
    chk({tag, "_overrun"}, {31'd0, coll_overrun}, {31'd0, ovr});
  endtask

  initial begin
    rst = 1'b1; de_in = 1'b0; frame_in = 1'b0; px_x = '0; px_y = '0;
    spr_en = '0; spr_x = '0; spr_y = '0; spr_w = '0; spr_h = '0; spr_color = '0;
    clk_blink = 1'b0; blink_req = '0; coll_ack = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sx[i] = 0; sy[i] = 0; sw[i] = 0; sh[i] = 0; scol[i] = BG;
    end
    repeat (3) @(negedge clk);
    chk("rst_vga", {24'd0, vga_out}, {24'd0, BG});
    chk("rst_de", {31'd0, de_out}, 32'd0);
    chk_coll("rst", '0, 1'b0, 1'b0);
    chk("rst_blinking", {24'd0, blinking}, 32'd0);
    rst = 1'b0;

    // Single sprite row sweep, including both horizontal edges
    set_spr(0, 100, 50, 10, 4, WHITE, 1'b1);
    sweep(51, 95, 112);
    sweep(54, 100, 102);

    // Overlapping pair: priority and a first report
    set_spr(0, 200, 60, 8, 4, RED, 1'b1);
    set_spr(1, 204, 60, 8, 4, GREEN, 1'b1);
    sweep(61, 198, 214);
    frame_end();
    idle(2);
    chk_coll("first", 8'h03, 1'b1, 1'b0);

    tick(0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk_coll("ack1", 8'h03, 1'b0, 1'b0);

    // Two unacknowledged frames merge into an overrun
    set_spr(2, 300, 60, 10, 4, YELLOW, 1'b1);
    set_spr(3, 305, 60, 10, 4, BLUE, 1'b1);
    sweep(61, 198, 214);
    frame_end();
    idle(2);
    chk_coll("ovr_a", 8'h03, 1'b1, 1'b0);
    sweep(61, 298, 318);
    frame_end();
    idle(2);
    chk_coll("ovr_b", 8'h0F, 1'b1, 1'b1);
    tick(0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk_coll("ovr_ack", 8'h0F, 1'b0, 1'b0);

    // Acknowledge landing on the report cycle: new frame replaces the old one
    sweep(61, 198, 214);
    frame_end();
    idle(2);
    chk_coll("pend", 8'h03, 1'b1, 1'b0);
    sweep(61, 298, 318);
    frame_end();
    tick(0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk_coll("ackframe", 8'h0C, 1'b1, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk_coll("ackframe_clr", 8'h0C, 1'b0, 1'b0);

    // Sprite against the right screen edge must not wrap to column 0
    set_spr(0, 200, 60, 8, 4, RED, 1'b0);
    set_spr(1, 204, 60, 8, 4, GREEN, 1'b0);
    set_spr(2, 300, 60, 10, 4, YELLOW, 1'b0);
    set_spr(3, 305, 60, 10, 4, BLUE, 1'b0);
    set_spr(4, 1020, 100, 10, 2, BLUE, 1'b1);
    sweep(100, 1016, 1023);
    sweep(100, 0, 5);
    sweep(101, 1021, 1023);
    set_spr(4, 1020, 100, 10, 2, BLUE, 1'b0);

    set_spr(0, 200, 60, 8, 4, RED, 1'b1);
    set_spr(1, 204, 60, 8, 4, GREEN, 1'b1);
`ifdef SPRITE_BLINK_EN
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("blink_start", {31'd0, blinking[0]}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle(2);
      tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      hid[0] = 1'b1;
      sweep(61, 202, 209);
      if (k == 0) begin
        frame_end();
        idle(2);
        chk_coll("hidden_coll", 8'h03, 1'b1, 1'b0);
        tick(0, 0, 1'b0, 1'b0, 1'b1);
      end
      idle(2);
      chk("blink_mid", {31'd0, blinking[0]}, 32'd1);
      tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      hid[0] = 1'b0;
      sweep(61, 202, 209);
    end
    idle(1);
    chk("blink_done", {31'd0, blinking[0]}, 32'd0);
`else
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sweep(61, 202, 209);
    chk("blink_off", {24'd0, blinking}, 32'd0);
`endif

    // Asynchronous reset in the middle of a frame drops the partial accumulation
    set_spr(2, 300, 60, 10, 4, YELLOW, 1'b1);
    set_spr(3, 305, 60, 10, 4, BLUE, 1'b1);
    sweep(61, 198, 214);
    #2;
    rst   = 1'b1;
    de_in = 1'b0;
    #1;
    chk("mid_rst_vga", {24'd0, vga_out}, {24'd0, BG});
    chk("mid_rst_de", {31'd0, de_out}, 32'd0);
    chk_coll("mid_rst", '0, 1'b0, 1'b0);
    chk("mid_rst_blinking", {24'd0, blinking}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    sweep(61, 298, 318);
    frame_end();
    idle(2);
    chk_coll("post_rst", 8'h0C, 1'b1, 1'b0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
